// File: rtl/imem_responder_if.sv
// Fetch-side bus between the control unit and the instruction memory
// responder: request/response handshake plus the preload write port.
interface imem_responder_if #(
  parameter int AW = 8
);
  logic          req;
  logic [63:0]   addr;
  logic          ack;
  logic [31:0]   instr;
  logic          err;
  logic          busy;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  modport master (
    output req, addr, ld_en, ld_addr, ld_data,
    input  ack, instr, err, busy
  );

  modport slave (
    input  req, addr, ld_en, ld_addr, ld_data,
    output ack, instr, err, busy
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time from IDLE,
// waits WAIT_CYCLES cycles, then pulses ack with the fetched word (or a
// NOP plus err for misaligned / out-of-range addresses). The word array
// can be preloaded whenever no fetch is in flight.
module imem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  imem_responder_if.slave   bus
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic          err_pend;
  logic [31:0]   instr_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH];

  logic          req_err;
  logic [AW-1:0] req_idx;
  logic          wr_en;
  logic [AW-1:0] rd_idx;
  logic          rd_err;
  logic [31:0]   rd_word;

  // Address check on the live bus address; only meaningful in the accepting cycle.
  assign req_err = (bus.addr[1:0] != 2'b00) || (|bus.addr[63:AW+2]);
  assign req_idx = bus.addr[AW+1:2];

  // Preload writes are only honoured while no fetch is in flight.
  assign wr_en = bus.ld_en && (state == S_IDLE);

  // With zero wait states the read happens on the accepting edge, so the
  // live address is used; otherwise the captured index is used.
  assign rd_idx = (state == S_IDLE) ? req_idx : idx_q;
  assign rd_err = (state == S_IDLE) ? req_err : err_pend;

  // A write landing on the same edge as the read is forwarded so the fetch
  // sees the newly written word.
  assign rd_word = (wr_en && (bus.ld_addr == rd_idx)) ? bus.ld_data : mem[rd_idx];

  assign bus.ack   = (state == S_RESP);
  assign bus.busy  = (state != S_IDLE);
  assign bus.instr = instr_q;
  assign bus.err   = err_q;

  // Word array: preload port only, deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  // Next-state decode for the fetch sequencer.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (bus.req) begin
          next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt <= 4'd1) begin
          next_state = S_RESP;
        end
      end
      S_RESP: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State register, request capture, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      idx_q    <= '0;
      err_pend <= 1'b0;
      instr_q  <= NOP;
      err_q    <= 1'b0;
    end else begin
      state <= next_state;

      if ((state == S_IDLE) && bus.req) begin
        cnt      <= WAIT_LOAD;
        idx_q    <= req_idx;
        err_pend <= req_err;
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      if ((next_state == S_RESP) && (state != S_RESP)) begin
        instr_q <= rd_err ? NOP : rd_word;
        err_q   <= rd_err;
      end else if (state == S_RESP) begin
        err_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: one instance with two wait states and one with
// none. Stimulus pushes expected {err, instr} into a per-instance queue and
// a monitor pops and compares on every ack.
module tb_imem_responder;
  localparam int          DEPTH = 256;
  localparam int          AW    = 8;
  localparam int          WA    = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;

  int compared   = 0;
  int mismatched = 0;

  logic [32:0] exp_a[$];
  logic [32:0] exp_b[$];

  logic prev_ack_a = 1'b0;
  logic prev_ack_b = 1'b0;

  imem_responder_if #(.AW(AW)) bus_a ();
  imem_responder_if #(.AW(AW)) bus_b ();

  imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WA)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the two-wait-state instance.
  always @(negedge clk) begin
    logic [32:0] e;
    if (bus_a.ack) begin
      check_output("a_ack_twice", 64'(prev_ack_a), 0);
      if (exp_a.size() == 0) begin
        check_output("a_unexpected_ack", 1, 0);
      end else begin
        e = exp_a.pop_front();
        check_output("a_instr", 64'(bus_a.instr), 64'(e[31:0]));
        check_output("a_err", 64'(bus_a.err), 64'(e[32]));
      end
    end else begin
      check_output("a_err_idle", 64'(bus_a.err), 0);
    end
    prev_ack_a <= bus_a.ack;
  end

  // Monitor for the zero-wait-state instance.
  always @(negedge clk) begin
    logic [32:0] e;
    if (bus_b.ack) begin
      check_output("b_ack_twice", 64'(prev_ack_b), 0);
      if (exp_b.size() == 0) begin
        check_output("b_unexpected_ack", 1, 0);
      end else begin
        e = exp_b.pop_front();
        check_output("b_instr", 64'(bus_b.instr), 64'(e[31:0]));
        check_output("b_err", 64'(bus_b.err), 64'(e[32]));
      end
    end else begin
      check_output("b_err_idle", 64'(bus_b.err), 0);
    end
    prev_ack_b <= bus_b.ack;
  end

  task automatic preload(input int sel, input logic [AW-1:0] idx, input logic [31:0] data);
    @(negedge clk);
    if (sel == 0) begin
      bus_a.ld_en = 1'b1; bus_a.ld_addr = idx; bus_a.ld_data = data;
    end else begin
      bus_b.ld_en = 1'b1; bus_b.ld_addr = idx; bus_b.ld_data = data;
    end
    @(negedge clk);
    bus_a.ld_en = 1'b0;
    bus_b.ld_en = 1'b0;
  endtask

  // One fetch on instance A. ld_mode: 0 none, 1 write in the accepting
  // cycle, 2 write attempted during WAIT.
  task automatic apply_stimulus(input logic [63:0] a, input logic [31:0] exp_i, input logic exp_e,
                                input int ld_mode, input logic [AW-1:0] li, input logic [31:0] ld);
    int lat    = 0;
    int busy_n = 0;
    bit seen   = 0;
    @(negedge clk);
    bus_a.req  = 1'b1;
    bus_a.addr = a;
    if (ld_mode == 1) begin
      bus_a.ld_en = 1'b1; bus_a.ld_addr = li; bus_a.ld_data = ld;
    end
    exp_a.push_back({exp_e, exp_i});
    @(posedge clk);
    #1;
    bus_a.req   = 1'b0;
    bus_a.addr  = 64'hFFFF_FFFF_FFFF_FFFD;
    bus_a.ld_en = 1'b0;
    if (ld_mode == 2) begin
      bus_a.ld_en = 1'b1; bus_a.ld_addr = li; bus_a.ld_data = ld;
    end
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus_a.busy) busy_n++;
      if (bus_a.ack) seen = 1;
      if (lat == 2) bus_a.ld_en = 1'b0;
    end
    bus_a.ld_en = 1'b0;
    check_output("a_ack_seen", 64'(seen), 1);
    check_output("a_ack_latency", 64'(lat), 64'(WA + 1));
    check_output("a_busy_cycles", 64'(busy_n), 64'(WA + 1));
    @(negedge clk);
    check_output("a_busy_after", 64'(bus_a.busy), 0);
    check_output("a_instr_hold", 64'(bus_a.instr), 64'(exp_i));
  endtask

  // Main sequence.
  initial begin
    int n;
    int cyc;
    int last;
    int first;
    logic [31:0] bvals [4];
    bvals[0] = 32'h0010_0093;
    bvals[1] = 32'h0020_0113;
    bvals[2] = 32'h0030_0193;
    bvals[3] = 32'h0040_0213;

    reset = 1'b1;
    bus_a.req = 1'b0; bus_a.addr = '0; bus_a.ld_en = 1'b0; bus_a.ld_addr = '0; bus_a.ld_data = '0;
    bus_b.req = 1'b0; bus_b.addr = '0; bus_b.ld_en = 1'b0; bus_b.ld_addr = '0; bus_b.ld_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset state");
    check_output("rst_ack", 64'(bus_a.ack), 0);
    check_output("rst_busy", 64'(bus_a.busy), 0);
    check_output("rst_err", 64'(bus_a.err), 0);
    check_output("rst_instr_a", 64'(bus_a.instr), 64'(NOP));
    check_output("rst_instr_b", 64'(bus_b.instr), 64'(NOP));

    preload(0, 8'd0,   32'hDEAD_BEEF);
    preload(0, 8'd5,   32'h00A0_0093);
    preload(0, 8'd6,   32'h00B0_0113);
    preload(0, 8'd255, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) preload(1, 8'(i), bvals[i]);

    $display("[TB] single fetches, two wait states");
    apply_stimulus(64'h14, 32'h00A0_0093, 1'b0, 0, '0, '0);
    apply_stimulus(64'h16, NOP, 1'b1, 0, '0, '0);
    apply_stimulus(64'h400, NOP, 1'b1, 0, '0, '0);
    apply_stimulus(64'h1_0000_0000, NOP, 1'b1, 0, '0, '0);
    apply_stimulus(64'h3FC, 32'hCAFE_F00D, 1'b0, 0, '0, '0);
    apply_stimulus(64'h0, 32'hDEAD_BEEF, 1'b0, 0, '0, '0);

    $display("[TB] preload while busy, preload with request");
    apply_stimulus(64'h18, 32'h00B0_0113, 1'b0, 2, 8'd5, 32'hFFFF_FFFF);
    apply_stimulus(64'h14, 32'h00A0_0093, 1'b0, 0, '0, '0);
    apply_stimulus(64'h1C, 32'h0BAD_C0DE, 1'b0, 1, 8'd7, 32'h0BAD_C0DE);

    $display("[TB] reset in second wait cycle");
    @(negedge clk);
    bus_a.req  = 1'b1;
    bus_a.addr = 64'h14;
    @(posedge clk);
    #1 bus_a.req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    check_output("abort_busy", 64'(bus_a.busy), 0);
    check_output("abort_instr", 64'(bus_a.instr), 64'(NOP));
    apply_stimulus(64'h14, 32'h00A0_0093, 1'b0, 0, '0, '0);

    $display("[TB] back-to-back, zero wait states");
    for (int i = 0; i < 4; i++) exp_b.push_back({1'b0, bvals[i]});
    @(negedge clk);
    bus_b.req  = 1'b1;
    bus_b.addr = 64'h0;
    n = 0; cyc = 0; last = -1; first = -1;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus_b.ack) begin
        if (last >= 0) check_output("b_ack_period", 64'(cyc - last), 2);
        else first = cyc;
        last = cyc;
        n++;
        bus_b.addr = bus_b.addr + 64'd4;
        if (n == 4) bus_b.req = 1'b0;
      end
    end
    check_output("b_ack_count", 64'(n), 4);
    check_output("b_first_latency", 64'(first), 1);

    $display("[TB] zero wait states, write forwarded to same-cycle fetch");
    @(negedge clk);
    @(negedge clk);
    bus_b.req = 1'b1; bus_b.addr = 64'h24;
    bus_b.ld_en = 1'b1; bus_b.ld_addr = 8'd9; bus_b.ld_data = 32'h1234_5678;
    exp_b.push_back({1'b0, 32'h1234_5678});
    @(posedge clk);
    #1;
    bus_b.req = 1'b0; bus_b.ld_en = 1'b0;
    @(negedge clk);
    check_output("b_bypass_ack", 64'(bus_b.ack), 1);

    repeat (4) @(negedge clk);
    check_output("a_queue_empty", 64'(exp_a.size()), 0);
    check_output("b_queue_empty", 64'(exp_b.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder on the fetch side of the multi-cycle RISC-V core. It answers fetch requests issued by the control unit during its fetch state. It returns the 32-bit instruction at the requested 64-bit byte address after a configurable number of wait states, and flags misaligned or out-of-range fetches. A preload port fills the word array before or between fetches.

## Interface
- DEPTH, 256: number of 32-bit instruction words; power of two, ≥ 4. AW = clog2(DEPTH).
- WAIT_CYCLES, 2: wait states between request acceptance and response; 0–15.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; one clock, synchronous active-high reset, as already decided.
- req  input  1  fetch request (level); sampled only in IDLE.
- addr  input  64  byte address from the program counter; captured when req is accepted.
- ack  output  1  single-cycle pulse; instr and err valid this cycle.
- instr  output  32  fetched instruction; holds its value until the next ack.
- err  output  1  asserted with ack when the captured address was misaligned or out of range.
- busy  output  1  high from the cycle after acceptance through the ack cycle.
- ld_en  input  1  preload write enable.
- ld_addr  input  AW  preload word index.
- ld_data  input  32  preload word.

## Operation
- Storage: DEPTH × 32 array. It is not cleared by reset.
- Address check, evaluated on the captured address:
  - misaligned if addr[1:0] ≠ 0;
  - out of range if addr[63:2] ≥ DEPTH.
  - Either condition gives err = 1.
- FSM states: IDLE, WAIT, RESP.
  - IDLE with req = 1: capture addr and the error flag. Load the wait counter with WAIT_CYCLES. Go to WAIT, or directly to RESP when WAIT_CYCLES = 0.
  - IDLE with req = 0: stay in IDLE.
  - WAIT: decrement the counter. When the counter reaches 1, go to RESP on the next edge. This gives exactly WAIT_CYCLES cycles in WAIT.
  - RESP: ack = 1 for one cycle, then go to IDLE unconditionally.
- Read data:
  - instr is registered on the edge entering RESP.
  - With err = 0, instr = mem[addr[AW+1:2]].
  - With err = 1, instr = 32'h0000_0013 (NOP, addi x0,x0,0).
  - err is registered on the same edge.
- req outside IDLE is ignored. Requests are not queued.
- A request still high in the IDLE cycle after RESP is accepted as a new fetch. The initiator drops req on ack when no further fetch is wanted.
- Preload:
  - ld_en is honoured only while busy = 0; while busy = 1 the write is dropped silently.
  - A write and an accepted req in the same IDLE cycle: the write commits, and the fetch returns the newly written word if the indices match.
- Reset, including mid-WAIT or mid-RESP, aborts the transaction. No ack is produced for an aborted fetch.

## Timing
- Reset values: state = IDLE, ack = 0, err = 0, busy = 0, instr = 32'h0000_0013, counter = 0.
- Request sampled high in IDLE at edge N:
  - busy = 1 from N+1;
  - ack = 1 during the cycle after edge N+1+WAIT_CYCLES;
  - busy falls together with ack.
- Minimum request-to-request period is WAIT_CYCLES + 2 cycles. With WAIT_CYCLES = 0, ack follows acceptance by one cycle and fetches repeat every 2 cycles.
- ack is never asserted for two consecutive cycles.
- err is 0 whenever ack is 0. err is cleared on the edge leaving RESP.
- instr keeps its value after ack until the next RESP entry.
- addr changes after acceptance have no effect.

## Test plan
- Basic fetch, WAIT_CYCLES = 2:
  - Stimulus: preload mem[5] = 32'h00A0_0093, then req with addr = 64'h14.
  - Response: ack exactly 3 cycles after acceptance, instr = 32'h00A0_0093, err = 0; busy high for 3 cycles.
- Misaligned fetch:
  - Stimulus: addr = 64'h16.
  - Response: ack with err = 1, instr = 32'h0000_0013.
- Out of range, DEPTH = 256:
  - Stimulus: addr = 64'h400, and separately addr = 64'h1_0000_0000.
  - Response: err = 1 and NOP in both cases, with no aliasing to mem[0].
- Back-to-back fetches:
  - Stimulus: req held high, addr stepping by 4 on each ack, WAIT_CYCLES = 0.
  - Response: ack every 2 cycles, instructions returned in address order.
- Preload while busy:
  - Stimulus: ld_en with ld_addr = 5 during WAIT.
  - Response: the write is ignored; a later fetch of 64'h14 returns the old word.
- Reset mid-WAIT:
  - Stimulus: assert reset for one cycle during the second WAIT cycle.
  - Response: no ack follows, busy = 0, instr = 32'h0000_0013; the next request completes normally.
